// File: rtl/fp_add_pkg.sv
// Shared widths for the single-precision adder mantissa datapath.
package fp_add_pkg;
    localparam int FRAC_W = 24;
    localparam int EXP_W  = 8;
endpackage

// File: rtl/fp_cla_adder.sv
// Carry-lookahead adder. Carries are generated in 4-bit lookahead groups, and each group passes its carry to the next.
module fp_cla_adder #(
    parameter int W = 25
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum
);
    localparam int NG = (W + 3) / 4;

    logic [W-1:0]  p;
    logic [W-1:0]  carry;
    logic [W-2:0]  g;
    logic [NG-1:0] gc;

    assign p     = a ^ b;
    assign g     = a[W-2:0] & b[W-2:0];
    assign gc[0] = cin;

    generate
        for (genvar gi = 0; gi < NG; gi++) begin : g_grp
            localparam int B = gi * 4;
            assign carry[B] = gc[gi];
            if (B + 1 < W) begin : g_c1
                assign carry[B+1] = g[B] | (p[B] & gc[gi]);
            end
            if (B + 2 < W) begin : g_c2
                assign carry[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & gc[gi]);
            end
            if (B + 3 < W) begin : g_c3
                assign carry[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                                  | (p[B+2] & p[B+1] & p[B] & gc[gi]);
            end
            // Only full groups feed a following group, so the MSB generate is never needed.
            if (gi < NG - 1) begin : g_gc
                assign gc[gi+1] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                                | (p[B+3] & p[B+2] & p[B+1] & g[B])
                                | ((&p[B+3:B]) & gc[gi]);
            end
        end
    endgenerate

    assign sum = p ^ carry;
endmodule

// File: rtl/fp_add_align_core.sv
// Mantissa align and add/subtract stage. It produces an unnormalised magnitude and the result sign after one register.
module fp_add_align_core
    import fp_add_pkg::*;
#(
    parameter int FRAC_W  = fp_add_pkg::FRAC_W,
    parameter int EXP_W   = fp_add_pkg::EXP_W,
    parameter int USE_CLA = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [EXP_W-1:0]  diff_exp,
    input  logic              sign_exp,
    input  logic [FRAC_W-1:0] fraction_a,
    input  logic [FRAC_W-1:0] fraction_b,
    input  logic              sign_a,
    input  logic              sign_b,
    input  logic              symbol,
    output logic              out_valid,
    output logic [FRAC_W:0]   out,
    output logic              sign_out
);
    logic              sb;
    logic              eff_sub;
    logic              a_gt_b;
    logic              a_eq_b;
    logic [FRAC_W-1:0] shift_src;
    logic [FRAC_W-1:0] shifted;
    logic [FRAC_W-1:0] m_a;
    logic [FRAC_W-1:0] m_b;
    logic [FRAC_W-1:0] op_x;
    logic [FRAC_W-1:0] op_y;
    logic [FRAC_W:0]   add_x;
    logic [FRAC_W:0]   add_y;
    logic [FRAC_W:0]   sum;
    logic              sign_next;

    logic              out_valid_reg;
    logic [FRAC_W:0]   out_reg;
    logic              sign_reg;

    assign sb        = sign_b ^ symbol;
    assign eff_sub   = sign_a ^ sb;
    assign shift_src = sign_exp ? fraction_a : fraction_b;
    assign shifted   = (diff_exp >= EXP_W'(FRAC_W)) ? '0 : (shift_src >> diff_exp);
    assign m_a       = sign_exp ? shifted : fraction_a;
    assign m_b       = sign_exp ? fraction_b : shifted;
    assign a_gt_b    = m_a > m_b;
    assign a_eq_b    = m_a == m_b;

    // On the subtract path the larger magnitude is always the minuend, so the difference never goes negative.
    assign op_x  = (eff_sub && !a_gt_b) ? m_b : m_a;
    assign op_y  = (eff_sub && !a_gt_b) ? m_a : m_b;
    assign add_x = {1'b0, op_x};
    assign add_y = eff_sub ? ~{1'b0, op_y} : {1'b0, op_y};

    generate
        if (USE_CLA != 0) begin : g_cla
            fp_cla_adder #(.W(FRAC_W + 1)) u_adder (
                .a   (add_x),
                .b   (add_y),
                .cin (eff_sub),
                .sum (sum)
            );
        end else begin : g_ripple
            assign sum = add_x + add_y + {{FRAC_W{1'b0}}, eff_sub};
        end
    endgenerate

    always_comb begin
        sign_next = sign_a;
        if (eff_sub) begin
            if (a_eq_b)
                sign_next = 1'b0;
            else if (a_gt_b)
                sign_next = sign_a;
            else
                sign_next = sb;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_reg       <= '0;
            sign_reg      <= 1'b0;
        end else begin
            out_valid_reg <= in_valid;
            if (in_valid) begin
                out_reg  <= sum;
                sign_reg <= sign_next;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out       = out_reg;
    assign sign_out  = sign_reg;
endmodule

// File: tb/tb_fp_add_align_core.sv
// Bench for the align core. Ripple and lookahead builds run side by side against a queue of expected results.
module tb_fp_add_align_core;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  diff_exp;
    logic        sign_exp;
    logic [23:0] fraction_a;
    logic [23:0] fraction_b;
    logic        sign_a;
    logic        sign_b;
    logic        symbol;

    logic        ov0, ov1, so0, so1;
    logic [24:0] o0, o1;
    logic [26:0] res [2];

    typedef struct {
        logic [24:0] out;
        logic        sign;
    } exp_t;

    exp_t sb_q [$];
    exp_t last_exp;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    fp_add_align_core #(.USE_CLA(0)) u_rip (
        .clk(clk), .rst(rst), .in_valid(in_valid), .diff_exp(diff_exp), .sign_exp(sign_exp),
        .fraction_a(fraction_a), .fraction_b(fraction_b), .sign_a(sign_a), .sign_b(sign_b),
        .symbol(symbol), .out_valid(ov0), .out(o0), .sign_out(so0)
    );

    fp_add_align_core #(.USE_CLA(1)) u_cla (
        .clk(clk), .rst(rst), .in_valid(in_valid), .diff_exp(diff_exp), .sign_exp(sign_exp),
        .fraction_a(fraction_a), .fraction_b(fraction_b), .sign_a(sign_a), .sign_b(sign_b),
        .symbol(symbol), .out_valid(ov1), .out(o1), .sign_out(so1)
    );

    assign res[0] = {ov0, o0, so0};
    assign res[1] = {ov1, o1, so1};

    function automatic exp_t model(input int unsigned de, input bit se, input int unsigned fa,
                                   input int unsigned fb, input bit sa, input bit sgb, input bit sym);
        exp_t        e;
        int unsigned ma, mb;
        bit          beff;
        beff = sgb ^ sym;
        ma   = fa;
        mb   = fb;
        if (se == 1'b0) mb = (de >= 24) ? 0 : (fb >> de);
        else            ma = (de >= 24) ? 0 : (fa >> de);
        if (sa == beff) begin
            e.out = 25'(ma + mb); e.sign = sa;
        end else if (ma > mb) begin
            e.out = 25'(ma - mb); e.sign = sa;
        end else if (mb > ma) begin
            e.out = 25'(mb - ma); e.sign = beff;
        end else begin
            e.out = '0; e.sign = 1'b0;
        end
        return e;
    endfunction

    task automatic drive(input int unsigned de, input bit se, input int unsigned fa, input int unsigned fb,
                         input bit sa, input bit sgb, input bit sym);
        @(negedge clk);
        in_valid   = 1'b1;
        diff_exp   = 8'(de);
        sign_exp   = se;
        fraction_a = 24'(fa);
        fraction_b = 24'(fb);
        sign_a     = sa;
        sign_b     = sgb;
        symbol     = sym;
        sb_q.push_back(model(de, se, fa, fb, sa, sgb, sym));
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(5, 0, 1500, 37500, 0, 0, 0);
        void'(sb_q.pop_front());
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (res[k] !== 27'd0) $display("FAIL reset[%0d] got %h expected 0", k, res[k]);
            else passed++;
        end
        $display("txn reset: out=%0d sign=%0d valid=%0d", o0, so0, ov0);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic run_vectors(input string name, input int n, input int unsigned de [], input bit se [],
                               input int unsigned fa [], input int unsigned fb [], input bit sa [],
                               input bit sgb [], input bit sym []);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            drive(de[i], se[i], fa[i], fb[i], sa[i], sgb[i], sym[i]);
            @(posedge clk); #1;
            e = sb_q.pop_front();
            last_exp = e;
            for (int k = 0; k < 2; k++) begin
                total++;
                if (res[k] !== {1'b1, e.out, e.sign})
                    $display("FAIL %s[%0d] dut%0d got valid=%0d out=%0d sign=%0d expected out=%0d sign=%0d",
                             name, i, k, res[k][26], res[k][25:1], res[k][0], e.out, e.sign);
                else passed++;
            end
            $display("txn %s[%0d]: diff=%0d se=%0d a=%0d b=%0d -> out=%0d sign=%0d", name, i,
                     de[i], se[i], fa[i], fb[i], o0, so0);
        end
    endtask

    task automatic test_directed();
        int unsigned de [] = '{5, 5, 5, 25, 5, 0, 0, 255, 24, 23};
        bit          se [] = '{0, 0, 1, 1, 1, 0, 0, 0, 1, 0};
        int unsigned fa [] = '{1500, 16777211, 1500, 1500, 15000, 1000, 3000, 9000, 16777215, 8388608};
        int unsigned fb [] = '{37500, 1500, 37500, 37500, 36500, 3000, 3000, 16777215, 4000, 16777215};
        bit          sa [] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
        bit          sgb[] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
        bit          sym[] = '{0, 0, 0, 0, 1, 1, 1, 0, 0, 1};
        run_vectors("directed", 10, de, se, fa, fb, sa, sgb, sym);
    endtask

    task automatic test_back_to_back();
        int unsigned de [] = new[24];
        bit          se [] = new[24];
        int unsigned fa [] = new[24];
        int unsigned fb [] = new[24];
        bit          sa [] = new[24];
        bit          sgb[] = new[24];
        bit          sym[] = new[24];
        for (int i = 0; i < 24; i++) begin
            de[i]  = (i % 7 == 6) ? 255 : $urandom_range(0, 27);
            se[i]  = 1'($urandom);
            fa[i]  = 32'h0080_0000 | ($urandom & 32'h007F_FFFF);
            fb[i]  = (i % 5 == 4) ? fa[i] : (32'h0080_0000 | ($urandom & 32'h007F_FFFF));
            sa[i]  = 1'($urandom);
            sgb[i] = 1'($urandom);
            sym[i] = 1'($urandom);
        end
        run_vectors("b2b", 24, de, se, fa, fb, sa, sgb, sym);
    endtask

    task automatic test_hold();
        @(negedge clk);
        in_valid   = 1'b0;
        fraction_a = 24'hABCDEF;
        fraction_b = 24'h123456;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            for (int k = 0; k < 2; k++) begin
                total++;
                if (res[k] !== {1'b0, last_exp.out, last_exp.sign})
                    $display("FAIL hold[%0d] dut%0d got %h expected %h", c, k, res[k],
                             {1'b0, last_exp.out, last_exp.sign});
                else passed++;
            end
            $display("txn hold[%0d]: out=%0d valid=%0d", c, o0, ov0);
        end
    endtask

    task automatic test_reset_midstream();
        drive(0, 0, 4000, 1000, 0, 0, 0);
        rst = 1'b1;
        void'(sb_q.pop_front());
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (res[k] !== 27'd0) $display("FAIL midrst dut%0d got %h expected 0", k, res[k]);
            else passed++;
        end
        $display("txn midrst: out=%0d valid=%0d", o0, ov0);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        diff_exp   = '0;
        sign_exp   = 1'b0;
        fraction_a = '0;
        fraction_b = '0;
        sign_a     = 1'b0;
        sign_b     = 1'b0;
        symbol     = 1'b0;
        test_reset();
        test_directed();
        test_hold();
        test_back_to_back();
        test_reset_midstream();
        test_directed();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
